// File: rtl/flip_flop.sv
// flip_flop: positive-edge D-type storage primitive used throughout the CPU
// datapath for register file bits, pipeline latches and flag latches.
//
// One WIDTH-bit state register samples D on every rising edge of CLK, with
// no enable. A synchronous active-high RST loads RESET_VALUE and takes
// priority over D. Qn is the bitwise complement of the stored value.
//
// Reset is tested with a strict equality against 1. An unconnected RST reads
// as z, so the comparison is not true and the register captures D. This keeps
// legacy instantiations that leave RST open working. The register has no
// power-on value: until the first qualifying edge it holds X in simulation,
// and Qn carries that X through the inversion.
//
// WIDTH is meant to stay within 1..64.

module flip_flop #(
    parameter int unsigned            WIDTH       = 1,
    parameter logic [WIDTH-1:0]       RESET_VALUE = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn
);

    // Stored value; Q drives it directly.
    logic [WIDTH-1:0] q_r;

    // Capture D on each rising edge; reset (strictly RST == 1) wins over D.
    always_ff @(posedge CLK) begin
        if (RST == 1'b1) begin
            q_r <= RESET_VALUE;
        end else begin
            q_r <= D;
        end
    end

    assign Q  = q_r;
    assign Qn = ~q_r;

endmodule

// File: tb/tb_flip_flop.sv
// tb_flip_flop: directed-vector bench for flip_flop. Three instances share
// one 10-unit clock (rising edges at 5, 15, 25, ...):
//   u1 - WIDTH 1, default reset value 0
//   u8 - WIDTH 8, RESET_VALUE 8'hA5
//   uf - WIDTH 1, reset pin tied to high impedance (floating)
// Inputs change on falling edges. Outputs are checked 1 unit after a rising
// edge, and also just before an edge to see the previously captured value.

module tb_flip_flop;

    logic       clk;
    logic       rst1;
    logic [0:0] d1;
    logic [0:0] q1;
    logic [0:0] qn1;

    logic       rst8;
    logic [7:0] d8;
    logic [7:0] q8;
    logic [7:0] qn8;

    wire        rst_float = 1'bz;
    logic [0:0] df;
    logic [0:0] qf;
    logic [0:0] qnf;

    int n_cmp;
    int n_err;

    flip_flop #(.WIDTH(1)) u1 (
        .CLK(clk), .RST(rst1), .D(d1), .Q(q1), .Qn(qn1)
    );

    flip_flop #(.WIDTH(8), .RESET_VALUE(8'hA5)) u8 (
        .CLK(clk), .RST(rst8), .D(d8), .Q(q8), .Qn(qn8)
    );

    flip_flop #(.WIDTH(1)) uf (
        .CLK(clk), .RST(rst_float), .D(df), .Q(qf), .Qn(qnf)
    );

    // Free-running clock: low at time 0, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Backstop so the run always ends.
    initial begin
        #5000;
        $display("FAIL watchdog: got timeout, want finish before 5000");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %h, want %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic after_rise();
        @(posedge clk);
        #1;
    endtask

    logic [0:0] pat   [4];
    logic [0:0] pre_q [4];

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst1  = 1'b0;
        d1    = 1'b0;
        rst8  = 1'b1;
        d8    = 8'h3C;
        df    = 1'b0;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b0;
        pre_q[0] = 1'b0; pre_q[1] = 1'b1; pre_q[2] = 1'b0; pre_q[3] = 1'b1;

        // Edge at 5: u1 captures 0, u8 resets to A5 although D is 3C.
        after_rise();
        check_val("u1_first_capture", {63'd0, q1}, 64'd0);
        check_val("u8_reset_q", {56'd0, q8}, 64'h00000000000000A5);
        check_val("u8_reset_qn", {56'd0, qn8}, 64'h000000000000005A);

        // Basic capture: D = 1,0,1,0 set at 10,20,30,40; pre-edge sample at 14,24,...
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            d1 = pat[i];
            if (i == 0) rst8 = 1'b0;
            #4;
            check_val($sformatf("u1_pre_edge_%0d", i), {63'd0, q1}, {63'd0, pre_q[i]});
            after_rise();
            check_val($sformatf("u1_q_%0d", i), {63'd0, q1}, {63'd0, pat[i]});
            check_val($sformatf("u1_qn_%0d", i), {63'd0, qn1}, {63'd0, ~pat[i]});
            if (i == 0) check_val("u8_after_deassert", {56'd0, q8}, 64'h000000000000003C);
        end

        // Glitch on D entirely inside the low phase: Q stays 0.
        @(negedge clk);
        #1 d1 = 1'b1;
        #1 d1 = 1'b0;
        after_rise();
        check_val("u1_low_glitch", {63'd0, q1}, 64'd0);

        // Load 1, then change D during the high phase and cross a falling edge.
        @(negedge clk);
        d1 = 1'b1;
        after_rise();
        check_val("u1_load_one", {63'd0, q1}, 64'd1);
        d1 = 1'b0;
        @(negedge clk);
        #1;
        check_val("u1_hold_over_negedge", {63'd0, q1}, 64'd1);

        // Reset priority mid-stream: D = 1 with RST = 1 for two edges.
        d1   = 1'b1;
        rst1 = 1'b1;
        after_rise();
        check_val("u1_rst_edge1_q", {63'd0, q1}, 64'd0);
        check_val("u1_rst_edge1_qn", {63'd0, qn1}, 64'd1);
        @(negedge clk);
        after_rise();
        check_val("u1_rst_edge2_q", {63'd0, q1}, 64'd0);
        @(negedge clk);
        rst1 = 1'b0;
        after_rise();
        check_val("u1_rst_release", {63'd0, q1}, 64'd1);

        // u8: new data, then a mid-stream reset over different data.
        @(negedge clk);
        d8 = 8'h81;
        after_rise();
        check_val("u8_q_81", {56'd0, q8}, 64'h0000000000000081);
        check_val("u8_qn_7e", {56'd0, qn8}, 64'h000000000000007E);
        @(negedge clk);
        d8   = 8'hFF;
        rst8 = 1'b1;
        after_rise();
        check_val("u8_midstream_reset", {56'd0, q8}, 64'h00000000000000A5);
        @(negedge clk);
        rst8 = 1'b0;
        after_rise();
        check_val("u8_q_ff", {56'd0, q8}, 64'h00000000000000FF);

        // Floating reset: Q follows D with one-edge latency, never resets.
        @(negedge clk);
        df = 1'b1;
        after_rise();
        check_val("uf_q_1", {63'd0, qf}, 64'd1);
        check_val("uf_qn_0", {63'd0, qnf}, 64'd0);
        @(negedge clk);
        df = 1'b0;
        #4;
        check_val("uf_pre_edge", {63'd0, qf}, 64'd1);
        after_rise();
        check_val("uf_q_0", {63'd0, qf}, 64'd0);
        @(negedge clk);
        df = 1'b1;
        after_rise();
        @(negedge clk);
        after_rise();
        check_val("uf_hold_1", {63'd0, qf}, 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/flip_flop.md
# flip_flop

Positive-edge D-type register primitive used as the basic storage element throughout the CPU datapath (register file bits, pipeline and flag latches). It samples `D` on every rising edge of `CLK` and holds the value on `Q` until the next edge. A synchronous active-high reset forces a programmable reset value. The width is parameterised so one instance can serve as a single bit or a full register.

## Interface
- `WIDTH`, default 1: number of bits stored; legal range 1..64.
- `RESET_VALUE`, default 0 (all bits): value loaded into `Q` on reset; `WIDTH` bits wide.

- `CLK`  input  1  system clock; all state changes on the rising edge only.
- `RST`  input  1  reset, synchronous, active-high; sampled on the rising edge of `CLK`.
- `D`  input  `WIDTH`  data to capture.
- `Q`  output  `WIDTH`  registered data.
- `Qn`  output  `WIDTH`  bitwise complement of `Q`, combinational from the stored value.

## Operation
- Single state register of `WIDTH` bits; `Q` drives it directly.
- Rising edge of `CLK`:
  - `RST` = 1: the register loads `RESET_VALUE` and `D` is ignored.
  - `RST` = 0: the register loads `D`.
- No enable. The register reloads on every edge.
- `RST` has priority over `D` when both change in the same cycle.
- Reset value: `Q` = `RESET_VALUE` and `Qn` = ~`RESET_VALUE` after the first edge with `RST` = 1.
- Before the first rising edge, or if no edge has ever seen `RST` = 1 or a defined `D`, `Q` is unknown (X in simulation). No power-on initial value is provided.
- An unconnected `RST` (reads as z) must behave as deasserted. Implement the reset condition as a strict `RST == 1` check so that legacy 3-port instantiations still work.
- `Qn` always equals ~`Q`, including X propagation (~X = X).
- No asynchronous paths. Changes on `D` or `RST` between edges have no effect on `Q`.

## Timing
- Latency: one rising edge. The `D` value present just before edge N appears on `Q` after edge N (nonblocking update) and stays stable until edge N+1.
- A reader sampling `Q` at edge N sees the value captured at edge N-1, not the new value.
- Reset takes effect at the first rising edge with `RST` = 1. Deassertion takes effect at the first rising edge with `RST` = 0, when `D` is captured.
- Reset asserted mid-stream clears `Q` on that edge. The stored data is lost.
- Falling edges of `CLK` never change `Q`.

## Test plan
- Basic capture, `WIDTH` = 1, 10-unit clock (rising edges at 5, 15, 25, 35, 45), `D` toggled at 10, 20, 30, 40 as 1, 0, 1, 0:
  - After each edge at 15, 25, 35, 45, `Q` = 1, 0, 1, 0.
  - `Qn` = 0, 1, 0, 1.
- Sample-before-update: monitor `Q` at each rising edge using a pre-edge sample. Required readings at 25, 35, 45 are 1, 0, 1, i.e. the previous captured value.
- Reset priority: `D` = 1, `RST` = 1 for 2 edges -> `Q` = 0. Deassert `RST` with `D` = 1 -> `Q` = 1 after the next edge.
- Non-zero reset value: `WIDTH` = 8, `RESET_VALUE` = 8'hA5, `D` = 8'h3C, `RST` = 1 for one edge -> `Q` = 8'hA5 and `Qn` = 8'h5A. Next edge with `RST` = 0 -> `Q` = 8'h3C.
- Between-edge glitch: pulse `D` 0->1->0 entirely within the low phase of `CLK` -> `Q` unchanged.
- Floating reset: leave `RST` unconnected, drive `D` = 1, then 0 -> `Q` follows `D` with one-edge latency and never resets.
